seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: scans a 4-digit active-low 7-segment display (timer units, timer tens, '-', song number).
// Defining BLINK_ON_ZERO_EN adds blinking of the two timer digits while the timer reads 00.
module seg_scan_driver #(
  parameter int SCAN_DIV  = 50_000,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] TimerL,
  input  logic [3:0] TimerR,
  input  logic [2:0] en,
  output logic [7:0] Seg,
  output logic [3:0] Dig
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        idx;
  logic [1:0]        idx_next;
  logic              tick;
  logic              frame_wrap;
  logic [3:0]        snap_l;
  logic [3:0]        snap_r;
  logic [2:0]        snap_en;
  logic [3:0]        view_l;
  logic [3:0]        view_r;
  logic [2:0]        view_en;
  logic              blank_timer;
  logic [7:0]        seg_next;
  logic [3:0]        dig_next;

  function automatic logic [7:0] digit_code(input logic [3:0] v);
    case (v)
      4'd0:    digit_code = 8'hC0;
      4'd1:    digit_code = 8'hF9;
      4'd2:    digit_code = 8'hA4;
      4'd3:    digit_code = 8'hB0;
      4'd4:    digit_code = 8'h99;
      4'd5:    digit_code = 8'h92;
      4'd6:    digit_code = 8'h82;
      4'd7:    digit_code = 8'hF8;
      4'd8:    digit_code = 8'h80;
      4'd9:    digit_code = 8'h90;
      default: digit_code = 8'h86;
    endcase
  endfunction

  assign tick       = (scan_cnt == SCAN_LAST);
  assign idx_next   = idx + 2'd1;
  assign frame_wrap = tick && (idx == 2'd3);

  // Digit 0 is loaded on the same edge as the snapshot, so it must see the value being captured.
  assign view_l  = frame_wrap ? TimerL : snap_l;
  assign view_r  = frame_wrap ? TimerR : snap_r;
  assign view_en = frame_wrap ? en     : snap_en;

  always_ff @(posedge CLK) begin
    if (RST) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
    end else if (tick) begin
      scan_cnt <= '0;
      idx      <= idx_next;
    end else begin
      scan_cnt <= scan_cnt + SCAN_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      snap_l  <= 4'd0;
      snap_r  <= 4'd0;
      snap_en <= 3'd0;
    end else if (frame_wrap) begin
      snap_l  <= TimerL;
      snap_r  <= TimerR;
      snap_en <= en;
    end
  end

`ifdef BLINK_ON_ZERO_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

  logic [BLINK_W-1:0] blink_cnt;
  logic               phase_on;
  logic               zero_cond;

  assign zero_cond = (snap_l == 4'd0) && (snap_r == 4'd0) &&
                     ((snap_en == 3'b001) || (snap_en == 3'b010) || (snap_en == 3'b100));

  always_ff @(posedge CLK) begin
    if (RST || !zero_cond) begin
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase_on  <= ~phase_on;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  assign blank_timer = ~phase_on;
`else
  assign blank_timer = 1'b0;
`endif

  always_comb begin
    seg_next = 8'hFF;
    dig_next = 4'b1111;
    case (idx_next)
      2'd0: begin
        dig_next = 4'b1110;
        seg_next = blank_timer ? 8'hFF : digit_code(view_r);
      end
      2'd1: begin
        dig_next = 4'b1101;
        seg_next = blank_timer ? 8'hFF : digit_code(view_l);
      end
      2'd2: begin
        dig_next = 4'b1011;
        seg_next = 8'hBF;
      end
      default: begin
        dig_next = 4'b0111;
        case (view_en)
          3'b001:  seg_next = digit_code(4'd1);
          3'b010:  seg_next = digit_code(4'd2);
          3'b100:  seg_next = digit_code(4'd3);
          default: seg_next = 8'hFF;
        endcase
      end
    endcase
  end

  // Outputs only move on a tick, so Seg and Dig always change together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      Dig <= 4'b1111;
      Seg <= 8'hFF;
    end else if (tick) begin
      Dig <= dig_next;
      Seg <= seg_next;
    end
  end

endmodule
